// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_pkg : baud table, divisor helper and receiver state encoding    |
// |            shared by the UART transmitter and receiver               |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  localparam int unsigned BAUD_TABLE [8] = '{
    9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  function automatic int unsigned baud_rate(input logic [2:0] sel);
    return BAUD_TABLE[sel];
  endfunction

  // Rounded clocks per bit; only ever called with constant arguments.
  function automatic logic [15:0] baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    return 16'((clk_hz + baud_rate(sel) / 2) / baud_rate(sel));
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_if : serial line, baud select and byte handshake of uart_rx  |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
interface uart_rx_if;
  logic       rx;
  logic [2:0] baud_sel;
  logic [7:0] data_out;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;

  modport slave (
    input  rx, baud_sel, ready,
    output data_out, valid, busy, frame_err, overrun, parity_err
  );

  modport master (
    output rx, baud_sel, ready,
    input  data_out, valid, busy, frame_err, overrun, parity_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_sync : multi-flop synchronizer for the serial input, resets to  |
// |             the idle (1) level                                       |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx : 8N1 UART receiver with valid/ready byte output, framing,   |
// |           overrun and (with UART_PARITY_EN) even-parity checking     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave bus
);

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_START  = ST_START;
  localparam logic [2:0] S_DATA   = ST_DATA;
  localparam logic [2:0] S_PARITY = ST_PARITY;
  localparam logic [2:0] S_STOP   = ST_STOP;
  localparam logic [2:0] S_BREAK  = ST_BREAK;

  logic                 rxs;
  logic [15:0]          div_tab [8];
  logic                 bit_tick;
  logic                 half_tick;

  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [15:0]          div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] byte_q, byte_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
`ifdef UART_PARITY_EN
  logic                 par_q, par_d;
  logic                 perr_q, perr_d;
`endif

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.rx),
    .q_o   (rxs)
  );

  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    assign div_tab[gi] = baud_div(CLK_HZ, 3'(gi));
  end

  assign bit_tick  = (cnt_q == div_q - 16'd1);
  assign half_tick = (cnt_q == (div_q >> 1) - 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = 16'd0;
`ifdef UART_PARITY_EN
        par_d = 1'b0;
`endif
        if (!rxs) begin
          div_d   = div_tab[bus.baud_sel];
          state_d = S_START;
        end
      end
      S_START: begin
        if (half_tick) begin
          cnt_d   = 16'd0;
          bit_d   = 3'd0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = 16'd0;
          shift_d = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
`ifdef UART_PARITY_EN
        if (bit_tick) begin
          cnt_d   = 16'd0;
          par_d   = rxs ^ (^shift_q);
          state_d = S_STOP;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = 16'd0;
`ifdef UART_PARITY_EN
          perr_d = par_q;
`endif
          if (!rxs) begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end else begin
            state_d = S_IDLE;
            byte_d  = shift_q;
`ifdef UART_PARITY_EN
            done_d  = !par_q;
`else
            done_d  = 1'b1;
`endif
          end
        end
      end
      S_BREAK: begin
        // Hold off start detection until the line has returned to idle.
        cnt_d = 16'd0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && bus.ready) valid_d = 1'b0;
    if (done_q) begin
      if (!valid_q || bus.ready) begin
        data_d  = byte_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      byte_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      byte_q  <= byte_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
`ifdef UART_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid     = valid_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.frame_err = ferr_q;
  assign bus.overrun   = ovr_q;
`ifdef UART_PARITY_EN
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx : self-checking bench for uart_rx (serial frame driver,   |
// |              expected-byte queue and error-pulse counters)           |
// | Revision   : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_uart_rx;

  localparam int unsigned CLK_HZ = 8_000_000;
  localparam int unsigned SYNC   = 2;
`ifdef UART_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef struct {
    int         sel;
    logic [7:0] data;
    bit         stop_ok;
    int         exp_hs;
    int         exp_ferr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if bus ();

  uart_rx #(.CLK_HZ(CLK_HZ), .SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    total++;
    if (act < lo || act > hi) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Reference timing, derived from the baud table with plain arithmetic.
  function automatic int ref_div(input int sel);
    int baud [8];
    baud = '{9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600};
    return $rtoi(real'(CLK_HZ) / real'(baud[sel]) + 0.5);
  endfunction

  function automatic int exp_latency(input int sel);
    int dv;
    dv = ref_div(sel);
    return dv / 2 + (9 + PAR_BITS) * dv + 1 + SYNC + 1;
  endfunction

  function automatic bit even_bit(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) if (d[i]) ones++;
    return (ones % 2) == 1;
  endfunction

  // Ready driver: 0 = held low, 1 = held high, 2 = random per cycle.
  int ready_mode = 1;
  initial begin
    bus.ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.ready = 1'b0;
        1:       bus.ready = 1'b1;
        default: bus.ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshakes are checked against the expected-byte queue.
  logic [7:0] expq [$];
  int   n_hs = 0, n_ferr = 0, n_ovr = 0, n_perr = 0, n_rise = 0, rise_cyc = 0;
  logic prev_valid = 1'b0;
  initial forever begin
    @(negedge clk);
    if (bus.valid === 1'b1 && prev_valid !== 1'b1) begin
      n_rise++;
      rise_cyc = cyc;
    end
    prev_valid = bus.valid;
    if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
      n_hs++;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_byte: got 0x%02h, expected no byte", bus.data_out);
      end else begin
        check("rx_byte", bus.data_out, expq.pop_front());
      end
    end
    if (bus.frame_err === 1'b1)  n_ferr++;
    if (bus.overrun === 1'b1)    n_ovr++;
    if (bus.parity_err === 1'b1) n_perr++;
  end

  int tx_start = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input bit stop_bit, input bit par_flip);
    int dv;
    bit bits [$];
    dv = ref_div(sel);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef UART_PARITY_EN
    bits.push_back(even_bit(d) ^ par_flip);
`else
    if (par_flip) bits.push_back(even_bit(d));
`endif
    bits.push_back(stop_bit);
    @(posedge clk);
    #1;
    bus.baud_sel = 3'(sel);
    tx_start = cyc;
    foreach (bits[k]) begin
      bus.rx = bits[k];
      if (k == 1) bus.baud_sel = 3'($urandom_range(0, 7));
      repeat (dv) @(posedge clk);
      #1;
    end
    bus.rx = 1'b1;
  endtask

  int b_hs, b_ferr, b_ovr, b_perr, b_rise;
  task automatic snap();
    b_hs = n_hs; b_ferr = n_ferr; b_ovr = n_ovr; b_perr = n_perr; b_rise = n_rise;
  endtask

  task automatic check_deltas(input string name, input int hs, input int ferr, input int ovr, input int perr);
    check({name, "_handshakes"}, n_hs - b_hs, hs);
    check({name, "_frame_err"},  n_ferr - b_ferr, ferr);
    check({name, "_overrun"},    n_ovr - b_ovr, ovr);
    check({name, "_parity_err"}, n_perr - b_perr, perr);
  endtask

  vec_t vt [6];

  initial begin
    int dv;
    int good_cnt, bad_cnt;

    vt[0] = '{sel: 3, data: 8'hA5, stop_ok: 1'b1, exp_hs: 1, exp_ferr: 0};
    vt[1] = '{sel: 4, data: 8'h00, stop_ok: 1'b1, exp_hs: 1, exp_ferr: 0};
    vt[2] = '{sel: 5, data: 8'hFF, stop_ok: 1'b1, exp_hs: 1, exp_ferr: 0};
    vt[3] = '{sel: 6, data: 8'h3C, stop_ok: 1'b0, exp_hs: 0, exp_ferr: 1};
    vt[4] = '{sel: 7, data: 8'h5A, stop_ok: 1'b1, exp_hs: 1, exp_ferr: 0};
    vt[5] = '{sel: 2, data: 8'h01, stop_ok: 1'b0, exp_hs: 0, exp_ferr: 1};

    bus.rx       = 1'b1;
    bus.baud_sel = 3'd0;
    rst_n        = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_data_out",   bus.data_out, 0);
    check("rst_valid",      bus.valid, 0);
    check("rst_busy",       bus.busy, 0);
    check("rst_frame_err",  bus.frame_err, 0);
    check("rst_overrun",    bus.overrun, 0);
    check("rst_parity_err", bus.parity_err, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wait_cyc(5);

    // Single frame with latency measurement.
    snap();
    expq.push_back(8'h55);
    send_frame(1, 8'h55, 1'b1, 1'b0);
    wait_cyc(10);
    check_range("lat_0x55", rise_cyc - tx_start, exp_latency(1) - 2, exp_latency(1) + 2);
    check("lat_valid_pulses", n_rise - b_rise, 1);
    check_deltas("lat", 1, 0, 0, 0);

    // Table-driven frames at various baud rates.
    for (int i = 0; i < 6; i++) begin
      snap();
      if (vt[i].exp_hs == 1) expq.push_back(vt[i].data);
      send_frame(vt[i].sel, vt[i].data, vt[i].stop_ok, 1'b0);
      wait_cyc(2 * ref_div(vt[i].sel) + 8);
      check_deltas($sformatf("vec%0d", i), vt[i].exp_hs, vt[i].exp_ferr, 0, 0);
    end

    // Back-to-back frames with different baud selects.
    snap();
    expq.push_back(8'hAA);
    expq.push_back(8'hEF);
    send_frame(2, 8'hAA, 1'b1, 1'b0);
    send_frame(3, 8'hEF, 1'b1, 1'b0);
    wait_cyc(20);
    check_deltas("b2b", 2, 0, 0, 0);
    check("b2b_queue_left", expq.size(), 0);

    // Overrun: consumer stalled across two frames.
    snap();
    ready_mode = 0;
    wait_cyc(2);
    expq.push_back(8'h12);
    send_frame(4, 8'h12, 1'b1, 1'b0);
    send_frame(4, 8'h34, 1'b1, 1'b0);
    wait_cyc(20);
    check("ovr_data_held", bus.data_out, 8'h12);
    check("ovr_valid_held", bus.valid, 1);
    check_deltas("ovr_stalled", 0, 0, 1, 0);
    ready_mode = 1;
    wait_cyc(4);
    check("ovr_valid_drop", bus.valid, 0);
    check("ovr_drained", n_hs - b_hs, 1);

    // Line break at baud select 1.
    snap();
    dv = ref_div(1);
    bus.baud_sel = 3'd1;
    @(posedge clk);
    #1 bus.rx = 1'b0;
    wait_cyc(12 * dv);
    check("brk_busy_held", bus.busy, 1);
    bus.rx = 1'b1;
    wait_cyc(6);
    check("brk_busy_release", bus.busy, 0);
    wait_cyc(3 * dv);
    check("brk_valid_pulses", n_rise - b_rise, 0);
    check_deltas("brk", 0, 1, 0, 0);

    // Short low glitch on idle line, then a real frame.
    snap();
    dv = ref_div(4);
    bus.baud_sel = 3'd4;
    @(posedge clk);
    #1 bus.rx = 1'b0;
    wait_cyc((3 * dv) / 10);
    bus.rx = 1'b1;
    wait_cyc(2 * dv);
    check("glitch_busy", bus.busy, 0);
    check_deltas("glitch", 0, 0, 0, 0);
    snap();
    expq.push_back(8'hC3);
    send_frame(4, 8'hC3, 1'b1, 1'b0);
    wait_cyc(20);
    check_deltas("after_glitch", 1, 0, 0, 0);

    // Reset in the middle of the data bits.
    snap();
    bus.baud_sel = 3'd4;
    @(posedge clk);
    #1 bus.rx = 1'b0;
    wait_cyc(dv);
    bus.rx = 1'b1;
    wait_cyc(dv + dv / 2);
    check("mid_busy_before_rst", bus.busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_busy_after_rst", bus.busy, 0);
    wait_cyc(12 * dv);
    check("mid_valid_pulses", n_rise - b_rise, 0);
    check_deltas("mid_rst", 0, 0, 0, 0);
    snap();
    expq.push_back(8'h81);
    send_frame(4, 8'h81, 1'b1, 1'b0);
    wait_cyc(20);
    check_deltas("after_rst", 1, 0, 0, 0);

`ifdef UART_PARITY_EN
    // Parity: wrong bit discards the byte, right bit delivers it.
    snap();
    send_frame(4, 8'h07, 1'b1, 1'b1);
    wait_cyc(20);
    check_deltas("par_bad", 0, 0, 0, 1);
    snap();
    expq.push_back(8'h07);
    send_frame(4, 8'h07, 1'b1, 1'b0);
    wait_cyc(20);
    check_deltas("par_good", 1, 0, 0, 0);
`endif

    // Randomized frames with random consumer stalls.
    snap();
    good_cnt = 0;
    bad_cnt  = 0;
    ready_mode = 2;
    for (int i = 0; i < 30; i++) begin
      int         sel;
      logic [7:0] d;
      bit         ok;
      sel = $urandom_range(3, 7);
      d   = 8'($urandom);
      ok  = ($urandom_range(0, 5) != 0);
      if (ok) begin
        expq.push_back(d);
        good_cnt++;
      end else begin
        bad_cnt++;
      end
      send_frame(sel, d, ok, 1'b0);
      wait_cyc($urandom_range(4, 40));
    end
    wait_cyc(50);
    ready_mode = 1;
    wait_cyc(20);
    check_deltas("random", good_cnt, bad_cnt, 0, 0);
    check("random_queue_left", expq.size(), 0);
    check("final_busy", bus.busy, 0);
    check("final_valid", bus.valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
